regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised integer register file with a per-register busy scoreboard and a hardware clear sequencer. It sits in the decode/writeback boundary of the RISC-V core. Decode reads operands and their busy state, and reserves a destination for long-latency ops such as loads. Writeback retires the data and releases the reservation. x0 is hardwired to zero and is never busy.

## Interface
- XLEN, 32, data width in bits
- NREG, 32, number of architectural registers (power of two, ≥4)
- AW, 5, address width, log2(NREG)

- clk  in  1  clock, rising edge
- nrst  in  1  reset, asynchronous, active-low
- radd1, radd2  in  AW  read addresses
- rs1, rs2  out  XLEN  read data, combinational
- rs1_busy, rs2_busy  out  1  addressed register has an outstanding reservation
- wen  in  1  write enable
- wadd  in  AW  write address
- wdata  in  XLEN  write data
- rsv_en  in  1  reserve (mark busy) register rsv_add
- rsv_add  in  AW  register to reserve
- flush  in  1  clear all busy bits (pipeline flush)
- clr_req  in  1  start clear sweep (single-cycle pulse)
- clr_busy  out  1  clear sweep in progress
- busy_cnt  out  AW+1  number of registers currently busy

## Operation
- Reset: all registers 0, all busy bits 0, FSM IDLE, sweep counter 0. Outputs: rs1/rs2=0, rsx_busy=0, clr_busy=0, busy_cnt=0.
- Reads are asynchronous: rsN = reg[raddN], rsN_busy = busy[raddN]. Address 0 always returns 0 and not busy.
- Write: at posedge with wen=1 and wadd≠0, reg[wadd]←wdata and busy[wadd]←0. wadd=0 is ignored.
- Reserve: at posedge with rsv_en=1 and rsv_add≠0, busy[rsv_add]←1. rsv_add=0 is ignored.
- Reserve and write to the same address in the same cycle: data is written, busy ends 1 (new producer wins).
- flush=1: all busy bits ←0 at the next edge. flush overrides a same-cycle rsv_en. A same-cycle write still updates data.
- busy_cnt is the registered popcount of the busy vector and is updated the same edge as the busy bits.
- FSM IDLE→CLEAR: taken on clr_req=1 in IDLE. On entry all busy bits ←0 and the counter is set to 1.
- FSM CLEAR: each cycle reg[counter]←0 and counter increments. When counter reaches NREG-1 that register is zeroed and the FSM returns to IDLE.
- During CLEAR:
  - wen, rsv_en, flush and clr_req are ignored.
  - Reads return current contents, which are partially cleared.
- Reset asserted mid-sweep aborts the sweep to IDLE with every register zeroed.

## Timing
- Read latency: 0 cycles (combinational from address and state).
- Write/reserve/flush are visible on read outputs the cycle after the edge. This applies when REGFILE_BYPASS_EN is undefined.
- clr_busy rises the edge after clr_req and stays high for exactly NREG-1 cycles. The first accepted write is on the edge where clr_busy is low again.
- busy_cnt range is 0..NREG-1. It never wraps, since x0 is never counted.

## Configuration
- REGFILE_BYPASS_EN defined:
  - Same-cycle forwarding on each read port. If wen=1, wadd≠0, wadd==raddN and clr_busy=0, then rsN=wdata and rsN_busy=0.
  - A same-cycle rsv_en to that address does not affect the forwarded busy value.
- REGFILE_BYPASS_EN undefined: no forwarding. The read port shows the old value and old busy until the edge.

## Test plan
- Reset, then read all addresses: rs1/rs2=0, busy=0, busy_cnt=0. Write x0=0xDEADBEEF: x0 still reads 0.
- rsv_en x5, next cycle write x5=0x12345678: busy[5]=1 for one cycle with busy_cnt=1, then x5 reads 0x12345678 with busy=0 and busy_cnt=0.
- Same cycle rsv_en x7 and wen x7=0xA5A5A5A5: after the edge x7=0xA5A5A5A5, busy[7]=1, busy_cnt=1.
- Reserve x1..x4, then flush together with rsv_en x9: all busy=0, busy_cnt=0.
- Write x3=0x55 with raddr1=3 the same cycle:
  - With REGFILE_BYPASS_EN, rs1=0x55 that cycle.
  - Without it, rs1 shows the old value, then 0x55.
- Fill x1..x31 with nonzero data, pulse clr_req:
  - clr_busy high for 31 cycles, and a wen x10 mid-sweep is dropped.
  - Afterwards all registers read 0.
  - Repeat with nrst pulsed at sweep cycle 10: clr_busy=0, all registers 0.

Source files
------------

// File: rtl/regfile_sb_if.sv
// Decode/writeback bus of the scoreboarded register file: read ports, write,
// reservation, flush and clear-sweep control. The DUT uses the slave modport.
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic [AW-1:0]   radd1;
  logic [AW-1:0]   radd2;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            wen;
  logic [AW-1:0]   wadd;
  logic [XLEN-1:0] wdata;
  logic            rsv_en;
  logic [AW-1:0]   rsv_add;
  logic            flush;
  logic            clr_req;
  logic            clr_busy;
  logic [AW:0]     busy_cnt;

  modport master (
    output radd1, radd2, wen, wadd, wdata, rsv_en, rsv_add, flush, clr_req,
    input  rs1, rs2, rs1_busy, rs2_busy, clr_busy, busy_cnt
  );

  modport slave (
    input  radd1, radd2, wen, wadd, wdata, rsv_en, rsv_add, flush, clr_req,
    output rs1, rs2, rs1_busy, rs2_busy, clr_busy, busy_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with per-register busy scoreboard and a clear sweep.
// Define REGFILE_BYPASS_EN to forward same-cycle writes onto the read ports.
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic        clk,
  input  logic        nrst,
  regfile_sb_if.slave bus
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  logic [0:0]      r_state;
  logic [AW-1:0]   r_swp_cnt;
  logic [NREG-1:0] r_busy;
  logic [AW:0]     r_busy_cnt;
  logic [XLEN-1:0] r_regs [NREG];

  logic            w_idle;
  logic            w_start;
  logic            w_wr;
  logic            w_rsv;
  logic            w_swp_last;
  logic [NREG-1:0] w_busy_nxt;

  function automatic logic [AW:0] f_popcnt(input logic [NREG-1:0] v);
    logic [AW:0] n;
    n = '0;
    for (int i = 0; i < NREG; i++) n = n + (AW+1)'(v[i]);
    return n;
  endfunction

  // All bus-side updates are gated off while the sweep owns the array.
  assign w_idle     = (r_state == S_IDLE);
  assign w_start    = w_idle && bus.clr_req;
  assign w_wr       = w_idle && bus.wen && (bus.wadd != '0);
  assign w_rsv      = w_idle && bus.rsv_en && (bus.rsv_add != '0) && !bus.flush;
  assign w_swp_last = (r_state == S_CLEAR) && (r_swp_cnt == AW'(NREG-1));

  // Reserve is applied after write so a same-cycle new producer keeps busy set.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_start || (w_idle && bus.flush)) begin
      w_busy_nxt = '0;
    end else begin
      if (w_wr)  w_busy_nxt[bus.wadd]    = 1'b0;
      if (w_rsv) w_busy_nxt[bus.rsv_add] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= S_IDLE;
      r_swp_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.clr_req) begin
            r_state   <= S_CLEAR;
            r_swp_cnt <= AW'(1);
          end
        end
        S_CLEAR: begin
          if (w_swp_last) begin
            r_state   <= S_IDLE;
            r_swp_cnt <= '0;
          end else begin
            r_swp_cnt <= r_swp_cnt + AW'(1);
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_swp_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= f_popcnt(w_busy_nxt);
    end
  end

  // Entry 0 is never written; the read mux also forces it to zero.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if ((r_state == S_CLEAR) && (r_swp_cnt == AW'(i)))
          r_regs[i] <= '0;
        else if (w_wr && (bus.wadd == AW'(i)))
          r_regs[i] <= bus.wdata;
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic w_fwd1;
  logic w_fwd2;

  // w_wr already excludes the sweep, so forwarding stops while clr_busy is high.
  assign w_fwd1 = w_wr && (bus.wadd == bus.radd1);
  assign w_fwd2 = w_wr && (bus.wadd == bus.radd2);

  assign bus.rs1      = (bus.radd1 == '0) ? '0 : (w_fwd1 ? bus.wdata : r_regs[bus.radd1]);
  assign bus.rs2      = (bus.radd2 == '0) ? '0 : (w_fwd2 ? bus.wdata : r_regs[bus.radd2]);
  assign bus.rs1_busy = (bus.radd1 != '0) && !w_fwd1 && r_busy[bus.radd1];
  assign bus.rs2_busy = (bus.radd2 != '0) && !w_fwd2 && r_busy[bus.radd2];
`else
  assign bus.rs1      = (bus.radd1 == '0) ? '0 : r_regs[bus.radd1];
  assign bus.rs2      = (bus.radd2 == '0) ? '0 : r_regs[bus.radd2];
  assign bus.rs1_busy = (bus.radd1 != '0) && r_busy[bus.radd1];
  assign bus.rs2_busy = (bus.radd2 != '0) && r_busy[bus.radd2];
`endif

  assign bus.clr_busy = (r_state == S_CLEAR);
  assign bus.busy_cnt = r_busy_cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb: reset, scoreboard, flush,
// forwarding behaviour and the clear sweep (including reset mid-sweep).
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic clk;
  logic nrst;
  int   checks;
  int   errors;

  regfile_sb_if #(.XLEN(XLEN), .AW(AW)) bus ();

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.wen     = 1'b0;
    bus.wadd    = '0;
    bus.wdata   = '0;
    bus.rsv_en  = 1'b0;
    bus.rsv_add = '0;
    bus.flush   = 1'b0;
    bus.clr_req = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    bus.radd1 = '0;
    bus.radd2 = '0;
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int a = 0; a < NREG; a++) begin
      bus.radd1 = AW'(a);
      bus.radd2 = AW'(NREG-1-a);
      #1;
      checks++;
      if (bus.rs1 !== '0 || bus.rs2 !== '0 || bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_read a=%0d rs1=%h rs2=%h b1=%b b2=%b required 0", a, bus.rs1, bus.rs2, bus.rs1_busy, bus.rs2_busy);
      end
    end
    checks++;
    if (bus.busy_cnt !== '0 || bus.clr_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_status busy_cnt=%0d clr_busy=%b required 0/0", bus.busy_cnt, bus.clr_busy);
    end
    nrst = 1'b1;
    tick();
    bus.wen = 1'b1; bus.wadd = '0; bus.wdata = 32'hDEADBEEF;
    tick();
    idle_inputs();
    bus.radd1 = '0;
    #1;
    checks++;
    if (bus.rs1 !== '0 || bus.rs1_busy !== 1'b0) begin
      errors++;
      $display("FAIL x0_write rs1=%h busy=%b required 0/0", bus.rs1, bus.rs1_busy);
    end
  endtask

  task automatic test_reserve_write;
    bus.rsv_en = 1'b1; bus.rsv_add = 5'd5;
    tick();
    idle_inputs();
    bus.radd1 = 5'd5;
    #1;
    checks++;
    if (bus.rs1_busy !== 1'b1 || bus.busy_cnt !== 6'd1) begin
      errors++;
      $display("FAIL reserve_x5 busy=%b cnt=%0d required 1/1", bus.rs1_busy, bus.busy_cnt);
    end
    bus.wen = 1'b1; bus.wadd = 5'd5; bus.wdata = 32'h12345678;
    tick();
    idle_inputs();
    #1;
    checks++;
    if (bus.rs1 !== 32'h12345678 || bus.rs1_busy !== 1'b0 || bus.busy_cnt !== 6'd0) begin
      errors++;
      $display("FAIL writeback_x5 rs1=%h busy=%b cnt=%0d required 12345678/0/0", bus.rs1, bus.rs1_busy, bus.busy_cnt);
    end
  endtask

  task automatic test_same_cycle;
    bus.rsv_en = 1'b1; bus.rsv_add = 5'd7;
    bus.wen = 1'b1; bus.wadd = 5'd7; bus.wdata = 32'hA5A5A5A5;
    tick();
    idle_inputs();
    bus.radd2 = 5'd7;
    #1;
    checks++;
    if (bus.rs2 !== 32'hA5A5A5A5 || bus.rs2_busy !== 1'b1 || bus.busy_cnt !== 6'd1) begin
      errors++;
      $display("FAIL rsv_wr_same rs2=%h busy=%b cnt=%0d required a5a5a5a5/1/1", bus.rs2, bus.rs2_busy, bus.busy_cnt);
    end
  endtask

  task automatic test_flush;
    for (int r = 1; r <= 4; r++) begin
      bus.rsv_en = 1'b1; bus.rsv_add = AW'(r);
      tick();
    end
    idle_inputs();
    #1;
    checks++;
    if (bus.busy_cnt !== 6'd5) begin
      errors++;
      $display("FAIL pre_flush_cnt cnt=%0d required 5", bus.busy_cnt);
    end
    bus.flush = 1'b1; bus.rsv_en = 1'b1; bus.rsv_add = 5'd9;
    tick();
    idle_inputs();
    #1;
    checks++;
    if (bus.busy_cnt !== 6'd0) begin
      errors++;
      $display("FAIL flush_cnt cnt=%0d required 0", bus.busy_cnt);
    end
    for (int r = 1; r <= 9; r++) begin
      bus.radd1 = AW'(r);
      #1;
      checks++;
      if (bus.rs1_busy !== 1'b0) begin
        errors++;
        $display("FAIL flush_busy x%0d busy=%b required 0", r, bus.rs1_busy);
      end
    end
  endtask

  task automatic test_bypass;
    logic [XLEN-1:0] exp_now;
    bus.wen = 1'b1; bus.wadd = 5'd3; bus.wdata = 32'h11;
    tick();
    bus.wdata = 32'h55;
    bus.radd1 = 5'd3;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_now = 32'h55;
`else
    exp_now = 32'h11;
`endif
    checks++;
    if (bus.rs1 !== exp_now) begin
      errors++;
      $display("FAIL same_cycle_read rs1=%h required %h", bus.rs1, exp_now);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (bus.rs1 !== 32'h55) begin
      errors++;
      $display("FAIL after_edge_read rs1=%h required 00000055", bus.rs1);
    end
  endtask

  task automatic fill_all;
    for (int r = 1; r < NREG; r++) begin
      bus.wen = 1'b1; bus.wadd = AW'(r); bus.wdata = 32'hC0DE0000 | r;
      tick();
    end
    idle_inputs();
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < NREG; a++) begin
      bus.radd1 = AW'(a);
      #1;
      checks++;
      if (bus.rs1 !== '0) begin
        errors++;
        $display("FAIL %s x%0d rs1=%h required 0", tag, a, bus.rs1);
      end
    end
  endtask

  task automatic test_clear;
    int n;
    fill_all();
    bus.radd1 = 5'd31;
    #1;
    checks++;
    if (bus.rs1 !== 32'hC0DE001F) begin
      errors++;
      $display("FAIL fill_x31 rs1=%h required c0de001f", bus.rs1);
    end
    bus.rsv_en = 1'b1; bus.rsv_add = 5'd12;
    tick();
    idle_inputs();
    bus.clr_req = 1'b1;
    tick();
    idle_inputs();
    n = 0;
    while (bus.clr_busy === 1'b1 && n < 100) begin
      if (n == 20) begin
        bus.wen = 1'b1; bus.wadd = 5'd10; bus.wdata = 32'hBAD0BAD0;
        bus.rsv_en = 1'b1; bus.rsv_add = 5'd11;
      end
      tick();
      idle_inputs();
      n++;
    end
    checks++;
    if (n !== NREG-1) begin
      errors++;
      $display("FAIL clr_busy_len cycles=%0d required %0d", n, NREG-1);
    end
    checks++;
    if (bus.busy_cnt !== 6'd0) begin
      errors++;
      $display("FAIL sweep_busy_cnt cnt=%0d required 0", bus.busy_cnt);
    end
    check_all_zero("sweep_zero");
    bus.wen = 1'b1; bus.wadd = 5'd10; bus.wdata = 32'h77;
    tick();
    idle_inputs();
    bus.radd1 = 5'd10;
    #1;
    checks++;
    if (bus.rs1 !== 32'h77) begin
      errors++;
      $display("FAIL post_sweep_write rs1=%h required 00000077", bus.rs1);
    end
  endtask

  task automatic test_reset_mid_sweep;
    fill_all();
    bus.clr_req = 1'b1;
    tick();
    idle_inputs();
    repeat (9) tick();
    checks++;
    if (bus.clr_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_sweep_busy clr_busy=%b required 1", bus.clr_busy);
    end
    nrst = 1'b0;
    #1;
    checks++;
    if (bus.clr_busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_clr_busy clr_busy=%b required 0", bus.clr_busy);
    end
    tick();
    nrst = 1'b1;
    check_all_zero("abort_zero");
    tick();
    checks++;
    if (bus.clr_busy !== 1'b0 || bus.busy_cnt !== 6'd0) begin
      errors++;
      $display("FAIL abort_status clr_busy=%b cnt=%0d required 0/0", bus.clr_busy, bus.busy_cnt);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nrst   = 1'b1;
    test_reset();
    test_reserve_write();
    test_same_cycle();
    test_flush();
    test_bypass();
    test_clear();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
